ysyx_23060184_mc_ctrl: RTL and testbench

//  Multi-cycle core sequencer. It replaces the single-cycle decode path with an FSM:

---
 rtl/ysyx_23060184_mc_ctrl_if.sv | 29 ++
 rtl/ysyx_23060184_mc_ctrl.sv | 108 ++++++++++
 tb/tb_ysyx_23060184_mc_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ysyx_23060184_mc_ctrl_if.sv
// ysyx_23060184_mc_ctrl_if: fetch/LSU handshakes and datapath controls between the sequencer and the core
interface ysyx_23060184_mc_ctrl_if #(parameter int INST_W = 32);
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic              inst_ready;
  logic              branch_taken;
  logic              lsu_req;
  logic              lsu_we;
  logic              lsu_done;
  logic              lsu_err;
  logic              reg_write;
  logic              csr_write;
  logic              pc_we;
  logic [1:0]        pc_sel;
  logic              trap_valid;
  logic [3:0]        trap_cause;
  logic              retire;
  logic [2:0]        state_o;
  modport master (
    input  inst_valid, inst, branch_taken, lsu_done, lsu_err,
    output inst_ready, lsu_req, lsu_we, reg_write, csr_write, pc_we, pc_sel,
           trap_valid, trap_cause, retire, state_o
  );
  modport slave (
    output inst_valid, inst, branch_taken, lsu_done, lsu_err,
    input  inst_ready, lsu_req, lsu_we, reg_write, csr_write, pc_we, pc_sel,
           trap_valid, trap_cause, retire, state_o
  );
endinterface

// File: rtl/ysyx_23060184_mc_ctrl.sv
// ysyx_23060184_mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with watchdog and precise traps
module ysyx_23060184_mc_ctrl #(
  parameter int INST_W      = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input logic clk,
  input logic rst,
  ysyx_23060184_mc_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT_CYC);
  state_e            state_q, state_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [CNT_W-1:0]  wd_q, wd_d, wd_inc;
  logic [3:0]        cause_q, cause_d, mem_cause;
  logic [6:0]        opc;
  logic is_ld, is_st, is_br, is_jal, is_jalr, is_sys, is_csr, is_ecall, is_mret, legal;
  logic wd_hit, st_ok, in_exec_jump;
  assign opc       = inst_q[6:0];
  assign is_ld     = opc == 7'b0000011;
  assign is_st     = opc == 7'b0100011;
  assign is_br     = opc == 7'b1100011;
  assign is_jal    = opc == 7'b1101111;
  assign is_jalr   = opc == 7'b1100111;
  assign is_sys    = opc == 7'b1110011;
  assign is_csr    = is_sys && (inst_q[14:12] == 3'b001 || inst_q[14:12] == 3'b010);
  assign is_ecall  = inst_q == INST_W'(32'h0000_0073);
  assign is_mret   = inst_q == INST_W'(32'h3020_0073);
  assign legal     = opc inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                 7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1110011};
  assign mem_cause = is_st ? 4'd7 : 4'd5;
  // TIMEOUT_CYC of zero parks the counter at zero so it can never match
  assign wd_hit    = TIMEOUT_CYC != 0 && wd_q == TO;
  assign wd_inc    = (TIMEOUT_CYC == 0 || wd_q == TO) ? wd_q : wd_q + 1'b1;
  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    cause_d = cause_q;
    wd_d    = wd_q;
    case (state_q)
      S_FETCH:
        if (bus.inst_valid) begin
          inst_d  = bus.inst;
          state_d = S_DECODE;
        end else if (wd_hit) begin
          state_d = S_TRAP;
          cause_d = 4'd1;
        end else wd_d = wd_inc;
      S_DECODE: begin
        state_d = (!legal || is_ecall) ? S_TRAP : S_EXEC;
        cause_d = !legal ? 4'd2 : is_ecall ? 4'd11 : cause_q;
      end
      S_EXEC: begin
        state_d = (is_ld || is_st) ? S_MEM : (is_br || is_mret) ? S_FETCH : S_WB;
        wd_d    = (is_ld || is_st) ? '0 : wd_q;
      end
      S_MEM:
        if (bus.lsu_done) begin
          state_d = bus.lsu_err ? S_TRAP : is_st ? S_FETCH : S_WB;
          cause_d = bus.lsu_err ? mem_cause : cause_q;
        end else if (wd_hit) begin
          state_d = S_TRAP;
          cause_d = mem_cause;
        end else wd_d = wd_inc;
      default: state_d = S_FETCH;
    endcase
    if (state_d == S_FETCH && state_q != S_FETCH) wd_d = '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      inst_q  <= '0;
      wd_q    <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      wd_q    <= wd_d;
      cause_q <= cause_d;
    end
  end
  // a store commits in its lsu_done cycle, without visiting WB
  assign st_ok        = state_q == S_MEM && is_st && bus.lsu_done && !bus.lsu_err;
  assign in_exec_jump = state_q == S_EXEC && (is_br || is_mret);
  assign bus.inst_ready = state_q == S_FETCH;
  assign bus.lsu_req    = state_q == S_MEM;
  assign bus.lsu_we     = state_q == S_MEM && is_st;
  assign bus.reg_write  = state_q == S_WB && inst_q[11:7] != 5'd0;
  assign bus.csr_write  = (state_q == S_WB && is_csr) || state_q == S_TRAP;
  assign bus.pc_we      = state_q == S_WB || state_q == S_TRAP || in_exec_jump || st_ok;
  assign bus.pc_sel     = state_q == S_TRAP                 ? 2'd3 :
                          (state_q == S_EXEC && is_mret)    ? 2'd3 :
                          (state_q == S_EXEC && is_br)      ? {1'b0, bus.branch_taken} :
                          (state_q == S_WB && is_jal)       ? 2'd1 :
                          (state_q == S_WB && is_jalr)      ? 2'd2 : 2'd0;
  assign bus.trap_valid = state_q == S_TRAP;
  assign bus.trap_cause = state_q == S_TRAP ? cause_q : 4'd0;
  assign bus.retire     = state_q == S_WB || in_exec_jump || st_ok;
  assign bus.state_o    = state_q;
endmodule

// File: tb/tb_ysyx_23060184_mc_ctrl.sv
// tb_ysyx_23060184_mc_ctrl: cycle-by-cycle vector table plus hand sequences for timeout and reset cases
module tb_ysyx_23060184_mc_ctrl;
  typedef struct {
    logic        r, iv;
    logic [31:0] in;
    logic        bt, dn, er;
    logic [2:0]  st;
    logic [13:0] o;
  } vec_t;
  localparam logic [31:0] ADDI  = 32'h0050_0093;
  localparam logic [31:0] LW    = 32'h0000_2103;
  localparam logic [31:0] SW    = 32'h0020_2023;
  localparam logic [31:0] ILL   = 32'hFFFF_FFFF;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] BEQ   = 32'h0000_0463;
  localparam logic [31:0] JAL   = 32'h0100_00EF;
  localparam logic [31:0] JALR  = 32'h0000_8067;
  localparam logic [31:0] CSRRW = 32'h3050_91F3;
  localparam logic [31:0] MRET  = 32'h3020_0073;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int failures = 0;
  vec_t q[$];
  ysyx_23060184_mc_ctrl_if #(.INST_W(32)) bus ();
  ysyx_23060184_mc_ctrl #(.INST_W(32), .TIMEOUT_CYC(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .bus(bus.master)
  );
  always #5 clk = ~clk;
  // expected outputs: rdy req we rw cw pwe psel tv tc ret
  function automatic vec_t mk(logic r, logic iv, logic [31:0] in, logic bt, logic dn, logic er,
                              logic [2:0] st, logic rdy, logic req, logic we, logic rw, logic cw,
                              logic pwe, logic [1:0] ps, logic tv, logic [3:0] tc, logic ret);
    vec_t v;
    v.r = r; v.iv = iv; v.in = in; v.bt = bt; v.dn = dn; v.er = er; v.st = st;
    v.o = {rdy, req, we, rw, cw, pwe, ps, tv, tc, ret};
    return v;
  endfunction
  function automatic vec_t fe(logic [31:0] in);
    return mk(0, 1, in, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0, 2'd0, 0, 4'd0, 0);
  endfunction
  function automatic vec_t qt(logic [2:0] st);
    return mk(0, 0, 32'd0, 0, 0, 0, st, 0, 0, 0, 0, 0, 0, 2'd0, 0, 4'd0, 0);
  endfunction
  function automatic vec_t trap(logic [3:0] tc);
    return mk(0, 0, 32'd0, 0, 0, 0, 3'd5, 0, 0, 0, 0, 1, 1, 2'd3, 1, tc, 0);
  endfunction
  task automatic run(input vec_t v, input string nm);
    logic [16:0] act, exp;
    @(negedge clk);
    rst = v.r;
    bus.inst_valid = v.iv;
    bus.inst = v.in;
    bus.branch_taken = v.bt;
    bus.lsu_done = v.dn;
    bus.lsu_err = v.er;
    #1;
    act = {bus.state_o, bus.inst_ready, bus.lsu_req, bus.lsu_we, bus.reg_write, bus.csr_write,
           bus.pc_we, bus.pc_sel, bus.trap_valid, bus.trap_cause, bus.retire};
    exp = {v.st, v.o};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got state=%0d outs=%b, want state=%0d outs=%b", nm, act[16:14], act[13:0],
               exp[16:14], exp[13:0]);
    end
  endtask
  initial begin
    bus.inst_valid = 0; bus.inst = 0; bus.branch_taken = 0; bus.lsu_done = 0; bus.lsu_err = 0;
    repeat (2) @(posedge clk);
    q.push_back(mk(0, 0, 32'd0, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0, 2'd0, 0, 4'd0, 0));
    q.push_back(fe(ADDI)); q.push_back(qt(1)); q.push_back(qt(2));
    q.push_back(mk(0, 0, 32'd0, 0, 0, 0, 3'd4, 0, 0, 0, 1, 0, 1, 2'd0, 0, 4'd0, 1));
    q.push_back(fe(LW)); q.push_back(qt(1)); q.push_back(qt(2));
    q.push_back(mk(0, 0, 32'd0, 0, 0, 0, 3'd3, 0, 1, 0, 0, 0, 0, 2'd0, 0, 4'd0, 0));
    q.push_back(mk(0, 0, 32'd0, 0, 0, 0, 3'd3, 0, 1, 0, 0, 0, 0, 2'd0, 0, 4'd0, 0));
    q.push_back(mk(0, 0, 32'd0, 0, 1, 0, 3'd3, 0, 1, 0, 0, 0, 0, 2'd0, 0, 4'd0, 0));
    q.push_back(mk(0, 0, 32'd0, 0, 0, 0, 3'd4, 0, 0, 0, 1, 0, 1, 2'd0, 0, 4'd0, 1));
    q.push_back(fe(SW)); q.push_back(qt(1)); q.push_back(qt(2));
    q.push_back(mk(0, 0, 32'd0, 0, 0, 0, 3'd3, 0, 1, 1, 0, 0, 0, 2'd0, 0, 4'd0, 0));
    q.push_back(mk(0, 0, 32'd0, 0, 0, 0, 3'd3, 0, 1, 1, 0, 0, 0, 2'd0, 0, 4'd0, 0));
    q.push_back(mk(0, 0, 32'd0, 0, 1, 0, 3'd3, 0, 1, 1, 0, 0, 1, 2'd0, 0, 4'd0, 1));
    q.push_back(fe(ILL)); q.push_back(qt(1)); q.push_back(trap(4'd2));
    q.push_back(fe(ECALL)); q.push_back(qt(1)); q.push_back(trap(4'd11));
    q.push_back(fe(BEQ)); q.push_back(qt(1));
    q.push_back(mk(0, 0, 32'd0, 1, 0, 0, 3'd2, 0, 0, 0, 0, 0, 1, 2'd1, 0, 4'd0, 1));
    q.push_back(fe(BEQ)); q.push_back(qt(1));
    q.push_back(mk(0, 0, 32'd0, 0, 0, 0, 3'd2, 0, 0, 0, 0, 0, 1, 2'd0, 0, 4'd0, 1));
    q.push_back(fe(JAL)); q.push_back(qt(1)); q.push_back(qt(2));
    q.push_back(mk(0, 0, 32'd0, 0, 0, 0, 3'd4, 0, 0, 0, 1, 0, 1, 2'd1, 0, 4'd0, 1));
    q.push_back(fe(JALR)); q.push_back(qt(1)); q.push_back(qt(2));
    q.push_back(mk(0, 0, 32'd0, 0, 0, 0, 3'd4, 0, 0, 0, 0, 0, 1, 2'd2, 0, 4'd0, 1));
    q.push_back(fe(CSRRW)); q.push_back(qt(1)); q.push_back(qt(2));
    q.push_back(mk(0, 0, 32'd0, 0, 0, 0, 3'd4, 0, 0, 0, 1, 1, 1, 2'd0, 0, 4'd0, 1));
    q.push_back(fe(MRET));
    q.push_back(mk(0, 1, ILL, 0, 0, 0, 3'd1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 4'd0, 0));
    q.push_back(mk(0, 0, 32'd0, 0, 0, 0, 3'd2, 0, 0, 0, 0, 0, 1, 2'd3, 0, 4'd0, 1));
    q.push_back(fe(LW)); q.push_back(qt(1)); q.push_back(qt(2));
    q.push_back(mk(0, 0, 32'd0, 0, 1, 1, 3'd3, 0, 1, 0, 0, 0, 0, 2'd0, 0, 4'd0, 0));
    q.push_back(trap(4'd5));
    q.push_back(fe(SW));
    q.push_back(mk(0, 0, 32'd0, 0, 1, 0, 3'd1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 4'd0, 0));
    q.push_back(mk(0, 0, 32'd0, 0, 1, 0, 3'd2, 0, 0, 0, 0, 0, 0, 2'd0, 0, 4'd0, 0));
    q.push_back(mk(0, 0, 32'd0, 0, 1, 1, 3'd3, 0, 1, 1, 0, 0, 0, 2'd0, 0, 4'd0, 0));
    q.push_back(trap(4'd7));
    foreach (q[i]) run(q[i], $sformatf("vec[%0d]", i));
    for (int i = 0; i < 5; i++)
      run(mk(0, 0, 32'd0, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0, 2'd0, 0, 4'd0, 0), "fetch_idle");
    run(trap(4'd1), "fetch_timeout");
    run(fe(LW), "hang_fetch"); run(qt(1), "hang_decode"); run(qt(2), "hang_exec");
    for (int i = 0; i < 5; i++)
      run(mk(0, 0, 32'd0, 0, 0, 0, 3'd3, 0, 1, 0, 0, 0, 0, 2'd0, 0, 4'd0, 0), "hang_mem");
    run(trap(4'd5), "mem_timeout");
    run(fe(LW), "late_fetch"); run(qt(1), "late_decode"); run(qt(2), "late_exec");
    for (int i = 0; i < 4; i++)
      run(mk(0, 0, 32'd0, 0, 0, 0, 3'd3, 0, 1, 0, 0, 0, 0, 2'd0, 0, 4'd0, 0), "late_mem");
    run(mk(0, 0, 32'd0, 0, 1, 0, 3'd3, 0, 1, 0, 0, 0, 0, 2'd0, 0, 4'd0, 0), "done_on_timeout");
    run(mk(0, 0, 32'd0, 0, 0, 0, 3'd4, 0, 0, 0, 1, 0, 1, 2'd0, 0, 4'd0, 1), "done_wins_wb");
    run(fe(LW), "rst_fetch"); run(qt(1), "rst_decode"); run(qt(2), "rst_exec");
    run(mk(0, 0, 32'd0, 0, 0, 0, 3'd3, 0, 1, 0, 0, 0, 0, 2'd0, 0, 4'd0, 0), "rst_mem");
    run(mk(1, 0, 32'd0, 0, 0, 0, 3'd3, 0, 1, 0, 0, 0, 0, 2'd0, 0, 4'd0, 0), "rst_in_mem");
    run(mk(0, 0, 32'd0, 0, 1, 0, 3'd0, 1, 0, 0, 0, 0, 0, 2'd0, 0, 4'd0, 0), "rst_late_done");
    run(mk(0, 0, 32'd0, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0, 2'd0, 0, 4'd0, 0), "rst_settled");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
